timebase_controller: RTL and testbench

Run/stop and burst controller for the one-second pulse timebase used by the FSM labs. It owns a programmable-period divider and accepts a period and burst length through a valid/ready handshake. On command it emits either a fixed number of one-cycle Pulse strobes or a continuous stream. Downstream FSMs (counters, displays, sequencers) consume Pulse as their tick enable.

---
 rtl/timebase_pkg.sv | 8 +
 rtl/period_divider.sv | 17 +
 rtl/timebase_controller.sv | 66 ++++++
 tb/tb_timebase_controller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// timebase_pkg: shared state encoding and period constants for the timebase
package timebase_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DEFAULT_PERIOD = 50_000_000;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/period_divider.sv
// period_divider: programmable terminal-count divider, held at zero while disabled
module period_divider #(
  parameter int CNT_W = 26
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic [CNT_W-1:0] Period,
  output logic             Tick
);
  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] last_q;
  assign last_q = Period - 1'b1;
  assign Tick = En && q == last_q;
  always_ff @(posedge Clk)
    q <= (!Resetn || !En || Tick) ? '0 : q + 1'b1;
endmodule

// File: rtl/timebase_controller.sv
// timebase_controller: run/stop and burst controller for the pulse timebase
module timebase_controller #(
  parameter int CNT_W = 26,
  parameter int BURST_W = 8,
  parameter int DEFAULT_PERIOD = timebase_pkg::DEFAULT_PERIOD
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               Cfg_Valid,
  output logic               Cfg_Ready,
  input  logic [CNT_W-1:0]   Cfg_Period,
  input  logic [BURST_W-1:0] Cfg_Burst,
  input  logic               Start,
  input  logic               Stop,
  output logic               Pulse,
  output logic               Done,
  output logic               Busy,
  output logic [BURST_W-1:0] Pulse_Count
);
  import timebase_pkg::*;
  logic [1:0] state;
  logic [CNT_W-1:0] period;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] cnt_nxt;
  logic tick, en, last;
  assign Cfg_Ready = state == IDLE;
  assign Busy = state != IDLE;
  assign en = state == RUN && !Stop;
  assign cnt_nxt = Pulse_Count + 1'b1;
  assign last = burst != '0 && cnt_nxt == burst;
  period_divider #(.CNT_W(CNT_W)) u_div (
    .Clk(Clk),
    .Resetn(Resetn),
    .En(en),
    .Period(period),
    .Tick(tick)
  );
  always_ff @(posedge Clk)
    if (!Resetn) begin
      state <= IDLE;
      period <= CNT_W'(DEFAULT_PERIOD);
      burst <= '0;
      Pulse <= 1'b0;
      Done <= 1'b0;
      Pulse_Count <= '0;
    end else begin
      Pulse <= tick;
      Done <= tick && last;
      if (state == IDLE) begin
        if (Cfg_Valid) begin
          period <= Cfg_Period < CNT_W'(MIN_PERIOD) ? CNT_W'(MIN_PERIOD) : Cfg_Period;
          burst <= Cfg_Burst;
        end
        if (Start && !Stop) begin
          state <= RUN;
          Pulse_Count <= '0;
        end
      end else if (state == RUN) begin
        if (Stop) state <= IDLE;
        else if (tick) begin
          Pulse_Count <= cnt_nxt;
          if (last) state <= DONE;
        end
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_timebase_controller.sv
// tb_timebase_controller: directed table and sequence checks for the timebase controller
module tb_timebase_controller;
  logic Clk = 1'b0;
  logic Resetn = 1'b0;
  logic Cfg_Valid = 1'b0;
  logic Cfg_Ready;
  logic [25:0] Cfg_Period = '0;
  logic [7:0] Cfg_Burst = '0;
  logic Start = 1'b0;
  logic Stop = 1'b0;
  logic Pulse, Done, Busy;
  logic [7:0] Pulse_Count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic v, s, st;
    logic [25:0] per;
    logic [7:0] bur;
    logic p, d, b, r;
    logic [7:0] c;
  } vec_t;
  vec_t tab[32];
  int n = 0;
  timebase_controller #(.CNT_W(26), .BURST_W(8), .DEFAULT_PERIOD(10)) dut (
    .Clk(Clk),
    .Resetn(Resetn),
    .Cfg_Valid(Cfg_Valid),
    .Cfg_Ready(Cfg_Ready),
    .Cfg_Period(Cfg_Period),
    .Cfg_Burst(Cfg_Burst),
    .Start(Start),
    .Stop(Stop),
    .Pulse(Pulse),
    .Done(Done),
    .Busy(Busy),
    .Pulse_Count(Pulse_Count)
  );
  always #5 Clk = ~Clk;
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input logic p, input logic d, input logic b, input logic r, input logic [7:0] c);
    chk({name, ".pulse"}, 32'(Pulse), 32'(p));
    chk({name, ".done"}, 32'(Done), 32'(d));
    chk({name, ".busy"}, 32'(Busy), 32'(b));
    chk({name, ".ready"}, 32'(Cfg_Ready), 32'(r));
    chk({name, ".count"}, 32'(Pulse_Count), 32'(c));
  endtask
  task automatic add(input logic v, input logic s, input logic st, input logic [25:0] per, input logic [7:0] bur,
                     input logic p, input logic d, input logic b, input logic r, input logic [7:0] c);
    tab[n] = '{v, s, st, per, bur, p, d, b, r, c};
    n++;
  endtask
  task automatic idle_in();
    Cfg_Valid = 1'b0;
    Start = 1'b0;
    Stop = 1'b0;
  endtask
  initial begin
    int bad;
    int dones;
    logic wrapped;
    logic [7:0] prev;
    add(1, 0, 0, 4, 3, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 2);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 3);
    step();
    step();
    chk_all("reset", 0, 0, 0, 1, 0);
    Resetn = 1'b1;
    for (int i = 0; i < n; i++) begin
      Cfg_Valid = tab[i].v;
      Start = tab[i].s;
      Stop = tab[i].st;
      Cfg_Period = tab[i].per;
      Cfg_Burst = tab[i].bur;
      step();
      chk_all($sformatf("vec%0d", i), tab[i].p, tab[i].d, tab[i].b, tab[i].r, tab[i].c);
    end
    idle_in();
    Cfg_Valid = 1'b1;
    Start = 1'b1;
    Cfg_Period = 4;
    Cfg_Burst = 5;
    step();
    idle_in();
    for (int i = 0; i < 8; i++) step();
    chk_all("midburst", 1, 0, 1, 0, 2);
    Resetn = 1'b0;
    step();
    chk_all("midreset", 0, 0, 0, 1, 0);
    Resetn = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (Pulse !== (k % 10 == 9) || Done !== 1'b0 || Pulse_Count !== 8'((k + 1) / 10) || Busy !== 1'b1) bad++;
    end
    chk("default_period_run", 32'(bad), 0);
    chk("default_period_count", 32'(Pulse_Count), 3);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk_all("stop_default", 0, 0, 0, 1, 3);
    Cfg_Valid = 1'b1;
    Cfg_Period = 4;
    Cfg_Burst = 0;
    Start = 1'b1;
    step();
    idle_in();
    bad = 0;
    dones = 0;
    wrapped = 1'b0;
    prev = Pulse_Count;
    for (int k = 0; k < 4400; k++) begin
      if (k == 100) begin
        Cfg_Valid = 1'b1;
        Cfg_Period = 7;
        chk("ready_in_run", 32'(Cfg_Ready), 0);
      end
      if (k == 101) Cfg_Valid = 1'b0;
      step();
      if (Pulse !== (k % 4 == 3)) bad++;
      if (Done !== 1'b0) dones++;
      if (prev == 8'd255 && Pulse_Count == 8'd0) wrapped = 1'b1;
      prev = Pulse_Count;
    end
    chk("cont_pattern", 32'(bad), 0);
    chk("cont_no_done", 32'(dones), 0);
    chk("cont_wrapped", 32'(wrapped), 1);
    chk("cont_count", 32'(Pulse_Count), 76);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk_all("cont_stop", 0, 0, 0, 1, 76);
    Cfg_Valid = 1'b1;
    Cfg_Period = 5;
    Start = 1'b1;
    step();
    idle_in();
    for (int i = 0; i < 5; i++) step();
    chk_all("p5_first", 1, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) step();
    chk("p5_before_stop", 32'(Pulse), 0);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk_all("stop_terminal", 0, 0, 0, 1, 1);
    step();
    chk("stop_no_late_pulse", 32'(Pulse), 0);
    Start = 1'b1;
    Stop = 1'b1;
    step();
    idle_in();
    chk_all("start_stop_idle", 0, 0, 0, 1, 1);
    step();
    chk("still_idle", 32'(Busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
